// File: rtl/mod_cnt_nco_if.sv
// Control/status bundle of the modulo counter with NCO tick enable.
// The master drives the controls; the slave (the counter) returns value, tick and carry.
interface mod_cnt_nco_if #(
    parameter int WIDTH = 6,
    parameter int NCO_W = 32
);
    logic [NCO_W-1:0] num;
    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             tick;
    logic             carry;

    modport master (
        output num, en, up, clr, load, load_val,
        input  out, tick, carry
    );

    modport slave (
        input  num, en, up, clr, load, load_val,
        output out, tick, carry
    );
endinterface

// File: rtl/mod_cnt_nco.sv
// Modulo-MOD up/down counter stepped by an internal NCO tick; carry pulses on wrap
// so that stages can be cascaded (carry of one stage feeds en of the next).
module mod_cnt_nco #(
    parameter int WIDTH = 6,
    parameter int MOD   = 60,
    parameter int NCO_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mod_cnt_nco_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    logic [NCO_W-1:0] nco_cnt;
    logic [NCO_W-1:0] period_m1;
    logic             nco_wrap;
    logic             tick_q;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] next_out;
    logic             carry_q;
    logic             next_carry;

    // num of 0 or 1 both collapse to a period of one cycle; >= lets a shrunk period wrap at once.
    always_comb begin
        period_m1 = (bus.num <= NCO_W'(1)) ? '0 : bus.num - NCO_W'(1);
        nco_wrap  = (nco_cnt >= period_m1);
    end

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nco_cnt <= '0;
            tick_q  <= 1'b0;
        end else if (bus.clr) begin
            nco_cnt <= '0;
            tick_q  <= 1'b0;
        end else if (nco_wrap) begin
            nco_cnt <= '0;
            tick_q  <= 1'b1;
        end else begin
            nco_cnt <= nco_cnt + NCO_W'(1);
            tick_q  <= 1'b0;
        end
    end

    // NOTE: defaults first so every path assigns next_out/next_carry and no latch is inferred.
    always_comb begin
        next_out   = out_q;
        next_carry = 1'b0;
        if (bus.load) begin
            next_out = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
        end else if (bus.en && tick_q) begin
            if (bus.up) begin
                next_carry = (out_q == MAX_VAL);
                next_out   = (out_q == MAX_VAL) ? '0 : out_q + WIDTH'(1);
            end else begin
                next_carry = (out_q == '0);
                next_out   = (out_q == '0) ? MAX_VAL : out_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            carry_q <= 1'b0;
        end else if (bus.clr) begin
            out_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            out_q   <= next_out;
            carry_q <= next_carry;
        end
    end

    assign bus.out   = out_q;
    assign bus.tick  = tick_q;
    assign bus.carry = carry_q;
endmodule

// File: tb/tb_mod_cnt_nco.sv
// Directed bench for mod_cnt_nco: a cycle-level arithmetic model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_mod_cnt_nco;
    localparam int WIDTH = 6;
    localparam int MOD   = 60;
    localparam int NCO_W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mod_cnt_nco_if #(.WIDTH(WIDTH), .NCO_W(NCO_W)) bus ();

    mod_cnt_nco #(.WIDTH(WIDTH), .MOD(MOD), .NCO_W(NCO_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int carry_seen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int     out;
        bit     carry;
        longint cnt;
        bit     tick;
    } model_t;

    model_t m;

    // One clock edge of the counter described in plain integer arithmetic.
    function automatic model_t model_next(model_t s, longint num_v, bit en_v, bit up_v,
                                          bit clr_v, bit load_v, int lv);
        model_t n = s;
        longint period = (num_v <= 1) ? 1 : num_v;
        if (clr_v) begin
            n.out = 0; n.carry = 0; n.cnt = 0; n.tick = 0;
            return n;
        end
        n.carry = 0;
        if (load_v) begin
            n.out = (lv < MOD) ? lv : MOD - 1;
        end else if (en_v && s.tick) begin
            if (up_v) begin
                n.carry = (s.out == MOD - 1);
                n.out   = (s.out + 1) % MOD;
            end else begin
                n.carry = (s.out == 0);
                n.out   = (s.out + MOD - 1) % MOD;
            end
        end
        if (s.cnt >= period - 1) begin
            n.cnt = 0; n.tick = 1;
        end else begin
            n.cnt = s.cnt + 1; n.tick = 0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{out: 0, carry: 1'b0, cnt: 0, tick: 1'b0};
        else        m <= model_next(m, longint'(bus.num), bus.en, bus.up, bus.clr,
                                    bus.load, int'(bus.load_val));
    end

    always @(negedge clk) begin
        check("model_out", 32'(bus.out), 32'(m.out));
        check("model_tick", 32'(bus.tick), 32'(m.tick));
        check("model_carry", 32'(bus.carry), 32'(m.carry));
        carry_seen += int'(bus.carry === 1'b1);
    end

    task automatic wait_out(input int v, input int budget);
        int k = 0;
        while (bus.out !== WIDTH'(v) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("reach_out", 32'(bus.out), 32'(v));
    endtask

    task automatic wait_tick(input int budget);
        int k = 0;
        while (bus.tick !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("reach_tick", 32'(bus.tick), 32'd1);
    endtask

    initial begin
        bus.num = 4; bus.en = 1'b0; bus.up = 1'b1;
        bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out", 32'(bus.out), 0);
        check("rst_tick", 32'(bus.tick), 0);
        check("rst_carry", 32'(bus.carry), 0);
        rst_n = 1'b1; bus.en = 1'b1;
        carry_seen = 0;

        // 1: first tick exactly num cycles after release, then full up-count with one carry
        repeat (3) @(negedge clk);
        check("first_tick_early", 32'(bus.tick), 0);
        @(negedge clk);
        check("first_tick", 32'(bus.tick), 1);
        check("first_tick_out", 32'(bus.out), 0);
        @(negedge clk);
        check("first_step_out", 32'(bus.out), 1);
        wait_out(59, 300);
        repeat (4) @(negedge clk);
        check("wrap_out", 32'(bus.out), 0);
        check("wrap_carry", 32'(bus.carry), 1);
        @(negedge clk);
        check("wrap_carry_gone", 32'(bus.carry), 0);
        check("carry_count", 32'(carry_seen), 1);

        // 2: down-count from 0 borrows to 59, then 58 without carry
        bus.clr = 1'b1; bus.up = 1'b0;
        @(negedge clk);
        check("clr_out", 32'(bus.out), 0);
        bus.clr = 1'b0;
        wait_out(59, 10);
        check("borrow_carry", 32'(bus.carry), 1);
        wait_out(58, 10);
        check("down_carry", 32'(bus.carry), 0);

        // 3: load, saturating load, load coincident with tick
        bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 6'd45;
        @(negedge clk);
        check("load_45", 32'(bus.out), 45);
        bus.load_val = 6'd63;
        @(negedge clk);
        check("load_sat", 32'(bus.out), 59);
        bus.load = 1'b0; bus.en = 1'b1; bus.up = 1'b1;
        wait_tick(10);
        bus.load = 1'b1; bus.load_val = 6'd10;
        @(negedge clk);
        check("load_on_tick", 32'(bus.out), 10);
        bus.load = 1'b0;

        // 4: clr with a tick in flight at out=30
        bus.load = 1'b1; bus.load_val = 6'd30;
        @(negedge clk);
        bus.load = 1'b0;
        wait_tick(10);
        check("pre_clr_out", 32'(bus.out), 30);
        bus.clr = 1'b1;
        @(negedge clk);
        check("clr_out30", 32'(bus.out), 0);
        check("clr_tick", 32'(bus.tick), 0);
        bus.clr = 1'b0;
        repeat (3) @(negedge clk);
        check("post_clr_no_tick", 32'(bus.tick), 0);
        @(negedge clk);
        check("post_clr_tick", 32'(bus.tick), 1);

        // 5: num=0 and num=1 tick every cycle; shrinking num wraps on the next edge
        bus.num = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("num0_tick", 32'(bus.tick), 1);
        end
        bus.num = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("num1_tick", 32'(bus.tick), 1);
        end
        bus.clr = 1'b1; bus.num = 100;
        @(negedge clk);
        bus.clr = 1'b0;
        repeat (50) @(negedge clk);
        check("num100_quiet", 32'(bus.tick), 0);
        bus.num = 4;
        @(negedge clk);
        check("shrink_tick", 32'(bus.tick), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("shrink_gap", 32'(bus.tick), 0);
        end
        @(negedge clk);
        check("shrink_period", 32'(bus.tick), 1);

        // Pause: en=0 holds out while the NCO keeps ticking
        bus.en = 1'b0;
        repeat (9) @(negedge clk);
        bus.en = 1'b1;

        // 6: asynchronous reset mid-count at out=17 with a tick in flight
        bus.load = 1'b1; bus.load_val = 6'd17;
        @(negedge clk);
        bus.load = 1'b0;
        check("pre_rst_out", 32'(bus.out), 17);
        wait_tick(10);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(bus.out), 0);
        check("async_rst_tick", 32'(bus.tick), 0);
        check("async_rst_carry", 32'(bus.carry), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit exceeded");
    end
endmodule
